// File: rtl/freq_div_pkg.sv
// Shared constants for the tick divider and its modulo counter.
package freq_div_pkg;

    // Counter step modes, as presented on the 2-bit mode input.
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Current travel direction; only bounce mode ever changes it.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_div_counter_tick_gen.sv
// Programmable divider: single-cycle tick enable and a registered square wave.
module tick_gen #(
    parameter int DIV_W = 27
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    output logic             strobe,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    // End of period: last count of the latched period while running.
    always_comb strobe = enable && (div_cnt_q == div_lat_q);

    // Next divider state; div_val is only sampled at a period boundary.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        if (strobe) begin
            div_cnt_d = '0;
            div_lat_d = div_val;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
        end else if (enable) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            div_cnt_q <= '0;
            div_lat_q <= div_val;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/tick_div_counter.sv
// Modulo counter (up/down/bounce/hold, synchronous load) advanced by a programmable tick.
module tick_div_counter
    import freq_div_pkg::*;
#(
    parameter int DIV_W = 27,
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             clk_out,
    output logic [CNT_W-1:0] Q,
    output logic             wrap
);

    logic             strobe;
    logic [CNT_W-1:0] q_q, q_d;
    dir_t             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .div_val (div_val),
        .strobe  (strobe),
        .tick    (tick),
        .clk_out (clk_out)
    );

    // Next counter state: load beats the strobe; wrap only pulses on a strobe.
    always_comb begin
        q_d    = q_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = (load_val > cnt_max) ? cnt_max : load_val;
        end else if (strobe) begin
            unique case (mode)
                MODE_UP: begin
                    // Covers both the normal wrap and a Q left above a lowered cnt_max.
                    if (q_q >= cnt_max) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if ((q_q > cnt_max) || (q_q == '0)) begin
                        q_d    = cnt_max;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (q_q > cnt_max) begin
                        q_d    = (dir_q == DIR_UP) ? '0 : cnt_max;
                        wrap_d = 1'b1;
                    end else if ((dir_q == DIR_UP) && (q_q == cnt_max)) begin
                        // Turn and step once; a zero modulus keeps Q pinned at 0.
                        dir_d  = DIR_DOWN;
                        wrap_d = 1'b1;
                        q_d    = (cnt_max == '0) ? '0 : q_q - 1'b1;
                    end else if ((dir_q == DIR_DOWN) && (q_q == '0)) begin
                        dir_d  = DIR_UP;
                        wrap_d = 1'b1;
                        q_d    = (cnt_max == '0) ? '0 : q_q + 1'b1;
                    end else begin
                        q_d = (dir_q == DIR_UP) ? q_q + 1'b1 : q_q - 1'b1;
                    end
                end
                default: begin
                    // Hold: Q and dir unchanged, wrap stays low.
                end
            endcase
        end
    end

    // Counter, direction and wrap registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            q_q    <= '0;
            dir_q  <= DIR_UP;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_tick_div_counter.sv
// Self-checking bench for tick_div_counter: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_tick_div_counter;
    import freq_div_pkg::*;

    localparam int DIV_W = 27;
    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] div_val;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt_max;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic             clk_out;
    logic [CNT_W-1:0] Q;
    logic             wrap;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_elapsed;
    int m_period;
    int m_q;
    bit m_tick;
    bit m_clk;
    bit m_wrap;
    bit m_up;

    tick_div_counter #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .div_val  (div_val),
        .mode     (mode),
        .cnt_max  (cnt_max),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .clk_out  (clk_out),
        .Q        (Q),
        .wrap     (wrap)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs presented to it.
    task automatic model_edge();
        bit strobe;
        int maxv;
        int t;
        if (reset) begin
            m_elapsed = 0;
            m_period  = int'(div_val) + 1;
            m_tick = 0; m_clk = 0; m_q = 0; m_wrap = 0; m_up = 1;
            return;
        end
        strobe = enable && (m_elapsed + 1 == m_period);
        m_tick = strobe;
        m_wrap = 0;
        if (strobe) begin
            m_clk     = !m_clk;
            m_elapsed = 0;
            m_period  = int'(div_val) + 1;
        end else if (enable) begin
            m_elapsed++;
        end
        maxv = int'(cnt_max);
        if (load) begin
            m_q = (int'(load_val) < maxv) ? int'(load_val) : maxv;
        end else if (strobe) begin
            case (mode)
                MODE_UP: begin
                    if (m_q > maxv) m_q = 0;
                    else m_q = (m_q + 1) % (maxv + 1);
                    m_wrap = (m_q == 0);
                end
                MODE_DOWN: begin
                    if (m_q > maxv || m_q == 0) begin
                        m_q = maxv; m_wrap = 1;
                    end else begin
                        m_q = m_q - 1;
                    end
                end
                MODE_BOUNCE: begin
                    t = m_up ? m_q + 1 : m_q - 1;
                    if (m_q > maxv) begin
                        m_q = m_up ? 0 : maxv; m_wrap = 1;
                    end else if (t < 0 || t > maxv) begin
                        m_up   = !m_up;
                        m_wrap = 1;
                        if (maxv == 0) m_q = 0;
                        else m_q = m_up ? m_q + 1 : m_q - 1;
                    end else begin
                        m_q = t;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: update model at the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check("tick", tick, m_tick);
        check("clk_out", clk_out, m_clk);
        check("Q", Q, m_q);
        check("wrap", wrap, m_wrap);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < budget);
        if (!tick) check("tick_timeout", 0, 1);
    endtask

    initial begin
        int ticks, wraps, n;
        int exp3 [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

        // 1: up count, period 4, modulus 16.
        reset = 1; enable = 1; div_val = 3; mode = MODE_UP; cnt_max = 15;
        load = 0; load_val = 0;
        step();
        reset = 0;
        check("rst_Q", Q, 0);
        check("rst_tick", tick, 0);
        check("rst_clk_out", clk_out, 0);
        check("rst_wrap", wrap, 0);
        ticks = 0; wraps = 0;
        repeat (64) begin
            step();
            ticks += int'(tick);
            wraps += int'(wrap);
        end
        check("t1_ticks", ticks, 16);
        check("t1_wraps", wraps, 1);
        check("t1_Q", Q, 0);

        // 2: down count, tick every cycle, modulus 10.
        reset = 1; div_val = 0; mode = MODE_DOWN; cnt_max = 9;
        step();
        reset = 0;
        ticks = 0; wraps = 0;
        repeat (20) begin
            step();
            ticks += int'(tick);
            wraps += int'(wrap);
        end
        check("t2_ticks", ticks, 20);
        check("t2_wraps", wraps, 2);
        check("t2_Q", Q, 0);

        // 3: bounce between 0 and 3.
        reset = 1; div_val = 1; mode = MODE_BOUNCE; cnt_max = 3;
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            wait_tick(8, n);
            check("t3_Q", Q, exp3[i]);
            check("t3_wrap", wrap, (i == 3 || i == 6) ? 1 : 0);
        end

        // 4: load coinciding with a strobe, load_val clipped to cnt_max.
        mode = MODE_UP; cnt_max = 9;
        n = 0;
        while (!(m_elapsed + 1 == m_period) && n < 16) begin
            step();
            n++;
        end
        load = 1; load_val = 12;
        step();
        load = 0;
        check("t4_Q", Q, 9);
        check("t4_wrap", wrap, 0);
        check("t4_tick", tick, 1);

        // 5: freeze mid-period, change div_val while frozen.
        reset = 1; div_val = 5; mode = MODE_UP; cnt_max = 15;
        step();
        reset = 0;
        step();
        step();
        enable = 0;
        ticks = 0;
        repeat (10) begin
            step();
            ticks += int'(tick);
            div_val = 1;
        end
        check("t5_frozen_ticks", ticks, 0);
        check("t5_frozen_Q", Q, 0);
        check("t5_frozen_clk", clk_out, 0);
        enable = 1;
        wait_tick(20, n);
        check("t5_first_gap", n, 4);
        wait_tick(20, n);
        check("t5_next_gap", n, 2);

        // 6: reset with Q=7, clk_out=1, dir=down.
        div_val = 0; mode = MODE_BOUNCE; cnt_max = 15;
        load = 1; load_val = 15;
        step();
        load = 0;
        repeat (3) step();
        n = 0;
        while (clk_out !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        enable = 0; load = 1; load_val = 7;
        step();
        load = 0;
        check("t6_pre_Q", Q, 7);
        check("t6_pre_clk", clk_out, 1);
        cnt_max = 3; enable = 1; reset = 1;
        step();
        reset = 0;
        check("t6_Q", Q, 0);
        check("t6_clk_out", clk_out, 0);
        check("t6_tick", tick, 0);
        check("t6_wrap", wrap, 0);
        step();
        check("t6_dir_up", Q, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 99) < 85);
            load     = ($urandom_range(0, 29) == 0);
            load_val = CNT_W'($urandom);
            if ($urandom_range(0, 49) == 0) div_val = DIV_W'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 59) == 0) cnt_max = CNT_W'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
